i2c_target_rx: RTL and testbench

- Write-only I2C target (responder) for the far end of the bus driven by the team's I2C master clock generator.
- Monitors the open-drain SCL/SDA lines and detects START/STOP.
- Matches the 7-bit address, ACKs write transfers and delivers each received byte on a valid/ready interface.
- Stretches SCL low after every data byte until the byte is consumed or a timeout expires.

---
 rtl/i2c_target_rx.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_rx
// Brief    : Write-only I2C target: address match, byte receive with ACK,
//            SCL stretching until each byte is consumed or times out.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_rx #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2,
    parameter int         STRETCH_MAX = 20000,
    parameter int         CBITS       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_STRETCH  = 3'd4,
        S_DATA_ACK = 3'd5,
        S_IGNORE   = 3'd6
    } state_t;

    localparam logic [CBITS-1:0] c_stretch_last = CBITS'(STRETCH_MAX - 1);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   byte_done_q, byte_done_d;
    logic [CBITS-1:0]       stretch_cnt_q, stretch_cnt_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d, timeout_q, timeout_d;

    logic w_s_scl, w_s_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_s_scl    = scl_sync_q[SYNC_STAGES-1];
    assign w_s_sda    = sda_sync_q[SYNC_STAGES-1];
    assign w_scl_rise = w_s_scl & ~scl_prev_q;
    assign w_scl_fall = ~w_s_scl & scl_prev_q;
    assign w_start    = sda_prev_q & ~w_s_sda & w_s_scl;
    assign w_stop     = ~sda_prev_q & w_s_sda & w_s_scl;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = w_s_scl;
        sda_prev_d = w_s_sda;
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_done_d   = byte_done_q;
        stretch_cnt_d = stretch_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        scl_oe_d      = scl_oe_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        timeout_d     = 1'b0;

        // Bus conditions override whatever the byte engine is doing.
        if (w_stop || w_start) begin
            state_d     = w_stop ? S_IDLE : S_ADDR;
            scl_oe_d    = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            rx_valid_d  = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else begin
            if (w_scl_rise && (state_q == S_ADDR || state_q == S_DATA)) begin
                shift_d   = {shift_q[6:0], w_s_sda};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d = 1'b1;
                end
            end

            case (state_q)
                S_ADDR: begin
                    if (w_scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (w_scl_fall) begin
                        sda_oe_d    = 1'b0;
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                        state_d     = S_DATA;
                    end
                end
                S_DATA: begin
                    // ACK is driven together with the stretch so it is ready on release.
                    if (w_scl_fall && byte_done_q) begin
                        rx_data_d     = shift_q;
                        rx_valid_d    = 1'b1;
                        scl_oe_d      = 1'b1;
                        sda_oe_d      = 1'b1;
                        stretch_cnt_d = '0;
                        byte_done_d   = 1'b0;
                        state_d       = S_STRETCH;
                    end
                end
                S_STRETCH: begin
                    stretch_cnt_d = stretch_cnt_q + CBITS'(1);
                    if (rx_valid_q && rx_ready) begin
                        rx_valid_d = 1'b0;
                        scl_oe_d   = 1'b0;
                        state_d    = S_DATA_ACK;
                    end else if (stretch_cnt_q == c_stretch_last) begin
                        rx_valid_d = 1'b0;
                        scl_oe_d   = 1'b0;
                        sda_oe_d   = 1'b0;
                        busy_d     = 1'b0;
                        timeout_d  = 1'b1;
                        state_d    = S_IGNORE;
                    end
                end
                S_IDLE, S_IGNORE: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q    <= '1;
            sda_sync_q    <= '1;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            byte_done_q   <= 1'b0;
            stretch_cnt_q <= '0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            scl_oe_q      <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            scl_sync_q    <= scl_sync_d;
            sda_sync_q    <= sda_sync_d;
            scl_prev_q    <= scl_prev_d;
            sda_prev_q    <= sda_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_done_q   <= byte_done_d;
            stretch_cnt_q <= stretch_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            scl_oe_q      <= scl_oe_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_rx
// Brief    : Self-checking bench: bit-level I2C master, consumer and a
//            transaction model of expected stretches, ACKs and bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;

    localparam logic [6:0] ADDR        = 7'h2A;
    localparam int         STRETCH_MAX = 100;
    localparam int         CBITS       = 7;
    localparam int         Q           = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_in, sda_in;
    logic       scl_oe, sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy, timeout;
    logic       m_scl, m_sda;

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign scl_in = m_scl & ~scl_oe;
    assign sda_in = m_sda & ~sda_oe;

    i2c_target_rx #(
        .ADDR        (ADDR),
        .SYNC_STAGES (2),
        .STRETCH_MAX (STRETCH_MAX),
        .CBITS       (CBITS)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .timeout  (timeout)
    );

    typedef struct {
        logic [7:0] data;
        int         len;
        logic       to;
    } stretch_t;

    stretch_t exp_q[$];
    int       n_cmp = 0;
    int       n_fail = 0;
    logic     model_busy = 1'b0;
    bit       mon_en = 1'b0;
    int       ready_delay = 0;
    logic     ready_hold = 1'b0;
    int       last_len = 0;
    int       n_hs = 0;
    int       n_to = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_q();
        repeat (Q) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (!scl_in && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("scl_release", scl_in, 1);
    endtask

    task automatic write_bit(input logic b, output logic s_mid, output logic s_end);
        m_sda = b;
        wait_q();
        m_scl = 1'b1;
        wait_scl_high();
        wait_q();
        s_mid = sda_in;
        wait_q();
        s_end = sda_in;
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s_mid, s_end;
        for (int i = 7; i >= 0; i--) begin
            write_bit(b[i], s_mid, s_end);
            chk("sda_line_bit", s_mid, b[i]);
            if (i == 7) chk("busy", busy, model_busy);
        end
        write_bit(1'b1, s_mid, s_end);
        chk({name, "_mid"}, !s_mid, exp_ack);
        chk({name, "_end"}, !s_end, exp_ack);
    endtask

    task automatic start_cond();
        if (!m_scl) begin
            m_sda = 1'b1;
            wait_q();
            m_scl = 1'b1;
            wait_scl_high();
            wait_q();
        end
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
        model_busy = 1'b0;
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_scl_high();
        wait_q();
        m_sda = 1'b1;
        wait_q();
        model_busy = 1'b0;
        chk("busy_after_stop", busy, 0);
        chk("sda_oe_after_stop", sda_oe, 0);
        chk("scl_oe_after_stop", scl_oe, 0);
    endtask

    // Model: an addressed write ACKs; each data byte is delivered, stretched
    // min(delay, STRETCH_MAX-1)+1 cycles, and NACKed with a timeout if the
    // consumer waits STRETCH_MAX cycles or more.
    task automatic send_txn(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input int n, input int delay, input bit do_stop);
        logic [7:0] db;
        logic       to;
        logic       match;
        stretch_t   r;
        ready_delay = delay;
        ready_hold  = (delay == 0);
        match       = (a[7:1] == ADDR) && !a[0];
        start_cond();
        write_byte(a, match, "addr_ack");
        model_busy = match;
        for (int i = 0; i < n; i++) begin
            db = (i == 0) ? d0 : d1;
            if (model_busy) begin
                to     = (delay >= STRETCH_MAX);
                r.data = db;
                r.len  = ((delay < STRETCH_MAX) ? delay : STRETCH_MAX - 1) + 1;
                r.to   = to;
                exp_q.push_back(r);
                write_byte(db, !to, "data_ack");
                if (to) model_busy = 1'b0;
            end else begin
                write_byte(db, 1'b0, "data_ack");
            end
        end
        if (do_stop) stop_cond();
    endtask

    initial begin : consumer
        int vcnt = 0;
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rx_valid) begin
                rx_ready = (vcnt >= ready_delay);
                vcnt++;
            end else begin
                rx_ready = ready_hold;
                vcnt = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic     prev_scl_oe;
        logic     prev_rst;
        int       run_len;
        stretch_t r;
        if (mon_en) begin
            if (scl_oe) begin
                if (!prev_scl_oe) begin
                    run_len = 1;
                    chk("stretch_expected", 32'(exp_q.size() != 0), 1);
                end else begin
                    run_len++;
                end
                if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q[0].data);
                chk("rx_valid_in_stretch", rx_valid, 1);
                chk("timeout_quiet", timeout, 0);
            end else begin
                chk("rx_valid_idle", rx_valid, 0);
                if (prev_scl_oe) begin
                    last_len = run_len;
                    if (exp_q.size() != 0) begin
                        r = exp_q.pop_front();
                        if (!prev_rst) begin
                            chk("stretch_len", run_len, r.len);
                            chk("timeout_pulse", timeout, r.to);
                        end
                    end
                end else begin
                    chk("timeout_quiet", timeout, 0);
                end
            end
            if (timeout) n_to++;
            if (rx_valid && rx_ready) n_hs++;
        end
        prev_scl_oe = scl_oe;
        prev_rst    = rst;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        stretch_t   r;
        logic [2:0] pb;
        logic       s_mid, s_end;

        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_q();

        // Reset while the target is holding SCL low.
        ready_delay = 1000;
        ready_hold  = 1'b0;
        start_cond();
        write_byte(8'h54, 1'b1, "addr_ack");
        model_busy = 1'b1;
        r.data = 8'h11;
        r.len  = 0;
        r.to   = 1'b0;
        exp_q.push_back(r);
        fork
            write_byte(8'h11, 1'b0, "rst_data_ack");
            begin : rst_thread
                int n = 0;
                while (!scl_oe && n < 3000) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                chk("stretch_reached", scl_oe, 1);
                repeat (10) @(posedge clk);
                #2;
                rst = 1'b1;
                model_busy = 1'b0;
                @(posedge clk);
                #2;
                rst = 1'b0;
                @(negedge clk);
                chk("midrst_scl_oe", scl_oe, 0);
                chk("midrst_sda_oe", sda_oe, 0);
                chk("midrst_rx_valid", rx_valid, 0);
                chk("midrst_busy", busy, 0);
            end
        join
        stop_cond();

        send_txn(8'h54, 8'hA5, 8'h00, 1, 0, 1'b1);
        chk("len_ready_held", last_len, 1);

        send_txn(8'h56, 8'hFF, 8'h00, 1, 0, 1'b1);
        send_txn(8'h55, 8'hC3, 8'h00, 1, 0, 1'b1);

        send_txn(8'h54, 8'h3C, 8'h00, 1, 1000, 1'b1);
        chk("len_timeout", last_len, 100);
        chk("timeout_count", n_to, 1);

        send_txn(8'h54, 8'h96, 8'h00, 1, 37, 1'b0);
        chk("len_ready_37", last_len, 38);
        pb = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            write_bit(pb[i], s_mid, s_end);
            chk("partial_bit", s_mid, pb[i]);
        end
        send_txn(8'h54, 8'h81, 8'h00, 1, 0, 1'b1);
        chk("len_after_rstart", last_len, 1);

        wait_q();
        chk("handshake_count", n_hs, 3);
        chk("timeout_total", n_to, 1);
        chk("stretch_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
